// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: loads a streamed program image into BRAM port B; readback verify enabled by IMEM_LOAD_VERIFY_EN
module imem_load_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  mem_enable,
  output logic [ADDR_WIDTH-1:0] mem_addr_b,
  output logic [DATA_WIDTH-1:0] mem_data_in_b,
  output logic                  mem_we_b,
  input  logic [DATA_WIDTH-1:0] mem_data_out_b,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_VERIFY_RD, S_VERIFY_CHK, S_DONE} state_t;
  localparam logic [ADDR_WIDTH:0]   LP_SIZE  = (ADDR_WIDTH+1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH:0]   LP_ONE_C = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] LP_ONE_A = ADDR_WIDTH'(1);
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic                  r_error;
  logic                  w_load;
  logic                  w_last;
`ifdef IMEM_LOAD_VERIFY_EN
  logic [ADDR_WIDTH-1:0] r_base;
  logic [DATA_WIDTH-1:0] r_wr_sum;
  logic [DATA_WIDTH-1:0] r_rd_sum;
`else
  logic                  w_unused;
  assign w_unused = ^mem_data_out_b;
`endif
  // rst gates s_ready so the word on the wire at the reset edge is never written
  assign w_load        = (r_state == S_LOAD) & ~rst;
  assign w_last        = r_cnt == r_count - LP_ONE_C;
  assign s_ready       = w_load;
  assign mem_we_b      = w_load & s_valid;
  assign mem_addr_b    = r_ptr;
  assign mem_data_in_b = s_data;
  assign mem_enable    = r_state inside {S_LOAD, S_VERIFY_RD, S_VERIFY_CHK};
  assign busy          = r_state != S_IDLE;
  assign cpu_hold      = r_state != S_IDLE;
  assign done          = r_state == S_DONE;
  assign error         = r_error;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_count <= '0;
      r_cnt   <= '0;
      r_error <= 1'b0;
`ifdef IMEM_LOAD_VERIFY_EN
      r_base   <= '0;
      r_wr_sum <= '0;
      r_rd_sum <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_ptr   <= base_addr;
          r_count <= word_count;
          r_cnt   <= '0;
          r_error <= word_count > LP_SIZE;
          r_state <= (word_count == '0 || word_count > LP_SIZE) ? S_DONE : S_LOAD;
`ifdef IMEM_LOAD_VERIFY_EN
          r_base   <= base_addr;
          r_wr_sum <= '0;
          r_rd_sum <= '0;
`endif
        end
        S_LOAD: if (s_valid) begin
          r_ptr <= r_ptr + LP_ONE_A;
          r_cnt <= r_cnt + LP_ONE_C;
`ifdef IMEM_LOAD_VERIFY_EN
          r_wr_sum <= r_wr_sum ^ s_data;
          if (w_last) begin
            r_state <= S_VERIFY_RD;
            r_ptr   <= r_base;
            r_cnt   <= '0;
          end
`else
          if (w_last) r_state <= S_DONE;
`endif
        end
`ifdef IMEM_LOAD_VERIFY_EN
        S_VERIFY_RD: begin
          r_ptr <= r_ptr + LP_ONE_A;
          r_cnt <= r_cnt + LP_ONE_C;
          if (r_cnt != '0) r_rd_sum <= r_rd_sum ^ mem_data_out_b;
          if (w_last) r_state <= S_VERIFY_CHK;
        end
        S_VERIFY_CHK: begin
          if ((r_rd_sum ^ mem_data_out_b) != r_wr_sum) r_error <= 1'b1;
          r_state <= S_DONE;
        end
`endif
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
